// File: rtl/nway_arbiter_buf_if.sv
// Handshake bundle for the N-way buffered arbiter. Tokens are {valid, payload}.
// A token transfers at a rising edge where its valid=1 and the matching stop=0; the producer holds it while stop=1.
interface nway_arbiter_buf_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*(W+1)-1:0] in_data;
  logic [N-1:0]       in_back_stop;
  logic [SW:0]        sel;
  logic               sel_back_stop;
  logic [W:0]         out_data;
  logic               down_stop;
  logic [SW:0]        chose;
  logic               chose_down_stop;
  logic               sel_err;
  logic [SW-1:0]      dbg_ptr;

  modport slave (
    input  in_data, sel, down_stop, chose_down_stop,
    output in_back_stop, sel_back_stop, out_data, chose, sel_err, dbg_ptr
  );

  modport master (
    output in_data, sel, down_stop, chose_down_stop,
    input  in_back_stop, sel_back_stop, out_data, chose, sel_err, dbg_ptr
  );
endinterface

// File: rtl/nway_arbiter_buf.sv
// N-way buffered arbiter: per-input FIFOs feed a steered (MODE=0) or round-robin (MODE=1)
// selector that loads two registered output slots (merged token and chosen channel index).
module nway_arbiter_buf #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  nway_arbiter_buf_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [W-1:0]  r_mem [N][DEPTH];
  logic [AW-1:0] r_rd  [N];
  logic [AW-1:0] r_wr  [N];
  logic [CW-1:0] r_cnt [N];
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_nempty;
  logic [N-1:0]  w_push;
  logic [N-1:0]  w_pop;

  logic [SW-1:0] r_smem [DEPTH];
  logic [AW-1:0] r_srd;
  logic [AW-1:0] r_swr;
  logic [CW-1:0] r_scnt;
  logic          w_sfull;
  logic          w_snempty;
  logic          w_spush;
  logic          w_spop;
  logic [SW-1:0] w_sel_idx;

  logic [W:0]    r_out_data;
  logic [SW:0]   r_chose;
  logic          r_sel_err;
  logic [SW-1:0] r_ptr;

  logic [SW-1:0] w_grant;
  logic          w_grant_ok;
  logic          w_bad_sel;
  logic          w_both_free;
  logic          w_fire;
  logic          w_drop;
  logic [W-1:0]  w_payload;
  int            w_scan;

  // Full blocks push even when the same edge pops, so stops depend on occupancy only.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_full[i]   = (r_cnt[i] == CW'(DEPTH));
      w_nempty[i] = (r_cnt[i] != '0);
      w_push[i]   = bus.in_data[i*(W+1) + W] && !w_full[i];
    end
  end

  assign w_sfull   = (r_scnt == CW'(DEPTH));
  assign w_snempty = (r_scnt != '0);
  assign w_spush   = (MODE == 0) && bus.sel[SW] && !w_sfull;
  assign w_sel_idx = r_smem[r_srd];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) r_wr[i] <= f_inc(r_wr[i]);
        if (w_pop[i])  r_rd[i] <= f_inc(r_rd[i]);
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_push[i]) r_mem[i][r_wr[i]] <= bus.in_data[i*(W+1) +: W];
    end
    if (w_spush) r_smem[r_swr] <= bus.sel[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_srd  <= '0;
      r_swr  <= '0;
      r_scnt <= '0;
    end else begin
      if (w_spush) r_swr <= f_inc(r_swr);
      if (w_spop)  r_srd <= f_inc(r_srd);
      if (w_spush && !w_spop)      r_scnt <= r_scnt + CW'(1);
      else if (!w_spush && w_spop) r_scnt <= r_scnt - CW'(1);
    end
  end

  // Steered mode never bypasses a waiting sel head; round-robin scans from r_ptr.
  always_comb begin
    w_grant    = '0;
    w_grant_ok = 1'b0;
    w_bad_sel  = 1'b0;
    w_scan     = 0;
    if (MODE == 0) begin
      if (w_snempty) begin
        if (int'(w_sel_idx) < N) begin
          w_grant    = w_sel_idx;
          w_grant_ok = w_nempty[w_sel_idx];
        end else begin
          w_bad_sel = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        w_scan = int'(r_ptr) + k;
        if (w_scan >= N) w_scan = w_scan - N;
        if (!w_grant_ok && w_nempty[w_scan[SW-1:0]]) begin
          w_grant    = w_scan[SW-1:0];
          w_grant_ok = 1'b1;
        end
      end
    end
  end

  assign w_both_free = (!r_out_data[W] || !bus.down_stop) && (!r_chose[SW] || !bus.chose_down_stop);
  assign w_fire      = w_both_free && w_grant_ok;
  assign w_drop      = w_both_free && w_bad_sel;
  assign w_spop      = (MODE == 0) && (w_fire || w_drop);
  assign w_payload   = r_mem[w_grant][r_rd[w_grant]];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pop[i] = w_fire && (w_grant == SW'(i));
    end
  end

  // Each output slot drains on its own stop; a new fire reloads both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_chose    <= '0;
      r_sel_err  <= 1'b0;
      r_ptr      <= '0;
    end else begin
      if (w_fire) begin
        r_out_data <= {1'b1, w_payload};
        r_chose    <= {1'b1, w_grant};
        if (MODE != 0) r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);
      end else begin
        if (!bus.down_stop)       r_out_data <= '0;
        if (!bus.chose_down_stop) r_chose    <= '0;
      end
      if (w_drop) r_sel_err <= 1'b1;
    end
  end

  assign bus.in_back_stop  = rst ? '1 : w_full;
  assign bus.sel_back_stop = rst || ((MODE == 0) && w_sfull);
  assign bus.out_data      = r_out_data;
  assign bus.chose         = r_chose;
  assign bus.sel_err       = r_sel_err;
  assign bus.dbg_ptr       = r_ptr;
endmodule

// File: tb/tb_nway_arbiter_buf.sv
// Directed bench for nway_arbiter_buf: steered N=4, round-robin N=4 and steered N=3 instances.
module tb_nway_arbiter_buf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nway_arbiter_buf_if #(.W(8), .N(4)) if0 ();
  nway_arbiter_buf_if #(.W(8), .N(4)) if1 ();
  nway_arbiter_buf_if #(.W(8), .N(3)) if2 ();

  nway_arbiter_buf #(.W(8), .N(4), .DEPTH(2), .MODE(0)) u_steer (.clk(clk), .rst(rst), .bus(if0));
  nway_arbiter_buf #(.W(8), .N(4), .DEPTH(2), .MODE(1)) u_rr    (.clk(clk), .rst(rst), .bus(if1));
  nway_arbiter_buf #(.W(8), .N(3), .DEPTH(2), .MODE(0)) u_n3    (.clk(clk), .rst(rst), .bus(if2));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [1:0] exp_ch_q[$];
  logic [1:0] ech;
  int sent[4];
  int recv[4];
  int nrx;

  typedef struct {
    int         ch;
    logic [7:0] pay;
    logic [8:0] exp_out;
    logic [2:0] exp_chose;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if0.in_data = '0; if0.sel = '0; if0.down_stop = 1'b0; if0.chose_down_stop = 1'b0;
    if1.in_data = '0; if1.sel = '0; if1.down_stop = 1'b0; if1.chose_down_stop = 1'b0;
    if2.in_data = '0; if2.sel = '0; if2.down_stop = 1'b0; if2.chose_down_stop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2, 8'hA1, 9'h1A1, 3'h6};
    vecs[1] = '{0, 8'h3C, 9'h13C, 3'h4};
    vecs[2] = '{3, 8'hFF, 9'h1FF, 3'h7};
    vecs[3] = '{1, 8'h00, 9'h100, 3'h5};

    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset out_data", if0.out_data, 0);
    check("reset chose", if0.chose, 0);
    check("reset in_back_stop", if0.in_back_stop, 0);
    check("reset sel_back_stop", if0.sel_back_stop, 0);
    check("reset sel_err", if0.sel_err, 0);
    check("reset rr ptr", if1.dbg_ptr, 0);

    // single steered transfers, 2 edges from accept to valid output
    for (int v = 0; v < 4; v++) begin
      if0.in_data[vecs[v].ch*9 +: 9] = {1'b1, vecs[v].pay};
      if0.sel = {1'b1, 2'(vecs[v].ch)};
      tick();
      if0.in_data = '0;
      if0.sel = '0;
      tick();
      check("vec out_data", if0.out_data, vecs[v].exp_out);
      check("vec chose", if0.chose, vecs[v].exp_chose);
      tick();
      check("vec drained", if0.out_data[8], 0);
    end

    // strict sel ordering: idx1 waits, ch0 may not bypass
    if0.in_data[0*9 +: 9] = {1'b1, 8'h55};
    if0.sel = 3'b101;
    tick();
    idle_all();
    tick(); tick(); tick();
    check("t2 wait out", if0.out_data, 0);
    check("t2 wait chose", if0.chose, 0);
    if0.in_data[1*9 +: 9] = {1'b1, 8'h77};
    tick();
    idle_all();
    tick();
    check("t2 out 77", if0.out_data, 9'h177);
    check("t2 chose 1", if0.chose, 3'h5);
    tick();
    check("t2 55 stays", if0.out_data[8], 0);
    if0.sel = 3'b100;
    tick();
    idle_all();
    tick();
    check("t2 out 55", if0.out_data, 9'h155);
    check("t2 chose 0", if0.chose, 3'h4);
    tick();

    // round-robin over ch0,1,3 with 3 tokens each
    for (int r = 0; r < 3; r++) begin
      exp_ch_q.push_back(2'd0);
      exp_ch_q.push_back(2'd1);
      exp_ch_q.push_back(2'd3);
    end
    for (int c = 0; c < 4; c++) begin sent[c] = 0; recv[c] = 0; end
    nrx = 0;
    for (int cyc = 0; cyc < 40 && nrx < 9; cyc++) begin
      if (if1.out_data[8] && !if1.down_stop) begin
        if (exp_ch_q.size() == 0) begin
          check("t3 extra token", 1, 0);
        end else begin
          ech = exp_ch_q.pop_front();
          check("t3 chose", if1.chose, {1'b1, ech});
          check("t3 payload", if1.out_data[7:0], 8'(ech * 16 + recv[ech]));
          recv[ech]++;
        end
        nrx++;
      end
      for (int c = 0; c < 4; c++) begin
        if (c != 2 && sent[c] < 3) begin
          if1.in_data[c*9 +: 9] = {1'b1, 8'(c * 16 + sent[c])};
          if (!if1.in_back_stop[c]) sent[c]++;
        end else begin
          if1.in_data[c*9 +: 9] = '0;
        end
      end
      tick();
    end
    check("t3 count", nrx, 9);
    check("t3 ptr wrapped", if1.dbg_ptr, 0);
    idle_all();
    tick();

    // backpressure on out_data while chose drains
    if0.down_stop = 1'b1;
    if0.in_data[0*9 +: 9] = {1'b1, 8'h10}; if0.sel = 3'b100;
    tick();
    if0.in_data[0*9 +: 9] = {1'b1, 8'h11};
    tick();
    check("t4 first out", if0.out_data, 9'h110);
    check("t4 first chose", if0.chose, 3'h4);
    if0.in_data[0*9 +: 9] = {1'b1, 8'h12};
    tick();
    if0.in_data = '0; if0.sel = '0;
    check("t4 chose drained", if0.chose, 0);
    check("t4 out held", if0.out_data, 9'h110);
    check("t4 ch0 stop", if0.in_back_stop[0], 1);
    check("t4 sel stop", if0.sel_back_stop, 1);
    tick();
    check("t4 out held 2", if0.out_data, 9'h110);
    check("t4 no fire", if0.chose, 0);
    tick();
    check("t4 out held 3", if0.out_data, 9'h110);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    if0.down_stop = 1'b0;
    nrx = 0;
    for (int k = 0; k < 8; k++) begin
      if (if0.out_data[8] && !if0.down_stop) begin
        if (exp_q.size() == 0) check("t4 extra token", 1, 0);
        else check("t4 drain payload", if0.out_data[7:0], exp_q.pop_front());
        nrx++;
      end
      tick();
    end
    check("t4 drain count", nrx, 3);
    check("t4 queue empty", exp_q.size(), 0);

    // out-of-range select on N=3
    if2.sel = 3'b111;
    tick();
    idle_all();
    tick();
    check("t5 sel_err set", if2.sel_err, 1);
    check("t5 no output", if2.out_data[8], 0);
    check("t5 sel popped", if2.sel_back_stop, 0);
    tick(); tick();
    check("t5 sel_err sticky", if2.sel_err, 1);
    if2.in_data[2*9 +: 9] = {1'b1, 8'h5A}; if2.sel = 3'b110;
    tick();
    idle_all();
    tick();
    check("t5 out after err", if2.out_data, 9'h15A);
    check("t5 chose after err", if2.chose, 3'h6);
    tick();

    // reset with outputs valid and FIFOs full
    if0.down_stop = 1'b1; if0.chose_down_stop = 1'b1;
    for (int c = 0; c < 4; c++) if0.in_data[c*9 +: 9] = {1'b1, 8'(8'h60 + c)};
    if0.sel = 3'b101;
    if1.in_data[2*9 +: 9] = {1'b1, 8'h99};
    tick();
    if1.in_data = '0;
    tick();
    check("t6 rr ptr moved", if1.dbg_ptr, 3);
    tick();
    check("t6 pre out", if0.out_data, 9'h161);
    check("t6 pre chose", if0.chose, 3'h5);
    check("t6 pre stops", if0.in_back_stop, 4'hF);
    rst = 1'b1;
    idle_all();
    #1;
    check("t6 stops in rst", if0.in_back_stop, 4'hF);
    check("t6 sel stop in rst", if0.sel_back_stop, 1);
    tick();
    rst = 1'b0;
    #1;
    check("t6 out cleared", if0.out_data, 0);
    check("t6 chose cleared", if0.chose, 0);
    check("t6 stops low", if0.in_back_stop, 0);
    check("t6 sel stop low", if0.sel_back_stop, 0);
    check("t6 ptr cleared", if1.dbg_ptr, 0);
    check("t6 sel_err cleared", if2.sel_err, 0);
    if0.sel = 3'b101;
    tick();
    idle_all();
    tick(); tick();
    check("t6 fifo emptied", if0.out_data[8], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
